nn_inference_sequencer: RTL
===========================

# nn_inference_sequencer

Batch controller that sits in front of `NeuralNetwork` and sequences inferences over a stored set of images. On `start` it pulses the network reset and streams each image word-by-word from an image RAM into the flat `NNin` vector. It then holds `NNvalid` until `maxValid` returns and reports the classification per image, repeating for `numImg` images. This replaces hand-driven stimulus with a synthesizable run loop for board bring-up.

## Interface
- `dataWidth`, 16, pixel / output word width
- `numInputs`, 784, pixels per image (words per `NNin`)
- `numImages`, 8, image slots in RAM; image `i` occupies addresses `i*numInputs .. i*numInputs+numInputs-1`
- `timeoutCycles`, 4096, max WAIT cycles before abandoning an image
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-low
- `start`  in  1  single-cycle request to begin a batch; ignored while `busy`
- `numImg`  in  4  images to run; sampled with `start`; values > `numImages` clamp to `numImages`
- `busy`  out  1  high from the cycle after accepted `start` until `done`
- `done`  out  1  one-cycle pulse at end of batch
- `memAddr`  out  $clog2(numImages*numInputs)  image RAM read address
- `memRd`  out  1  read strobe; `memData` is valid exactly 1 cycle later
- `memData`  in  dataWidth  RAM read data
- `nnReset`  out  1  active-high reset to `NeuralNetwork`
- `NNin`  out  numInputs*dataWidth  pixel k at `NNin[k*dataWidth +: dataWidth]`
- `NNvalid`  out  1  input-valid level to network
- `maxValid`, `maxIndex[3:0]`, `maxValue[dataWidth-1:0]`  in  result from network
- `resValid`  out  1  one-cycle pulse per finished image
- `resImg`  out  4  image number of the result
- `resIndex`  out  4  predicted class; 4'hF on timeout
- `resValue`  out  dataWidth  winning score; 0 on timeout
- `timeout`  out  1  sticky; set on any timeout, cleared on accepted `start`

## Operation
- States: IDLE, CLEAR, LOAD, FIRE, WAIT, REPORT, DONE.
- IDLE: `start`=1 captures clamped `numImg` into `total`, clears `img`, clears `timeout`. If `total`=0, go to DONE; otherwise go to CLEAR.
- CLEAR: `nnReset`=1 for exactly 2 cycles; `NNvalid`=0.
- LOAD: `memRd`=1 and `memAddr`=`img*numInputs+k` for k=0..numInputs-1 on consecutive cycles. The word read at k is written to pixel slot k the following cycle. Enter FIRE the cycle after the last capture.
- FIRE: assert `NNvalid`; enter WAIT the next cycle. `NNin` is frozen from FIRE through REPORT.
- WAIT: `NNvalid` held high; the counter increments each cycle.
  - `maxValid`=1: latch `maxIndex`/`maxValue`, go to REPORT.
  - counter reaches `timeoutCycles`: set `timeout`, latch 4'hF / 0, go to REPORT.
  - `maxValid` in any other state is ignored.
- REPORT: `NNvalid`=0; `resValid`=1 for one cycle with `resImg`=`img`. If `img+1`<`total`, increment `img` and go to CLEAR; else go to DONE.
- DONE: `done`=1 for one cycle, `busy` drops the same cycle, return to IDLE.
- Reset values:
  - all outputs 0 (including `NNin`, `nnReset`, `timeout`)
  - `resIndex`=0
  - state IDLE
- Reset asserted in any state aborts the batch immediately; no `done` or `resValid` is issued for the aborted work.

## Timing
- Accepted `start` at cycle 0 gives:
  - `busy`=1 from cycle 1
  - `nnReset` cycles 1–2
  - reads cycles 3..2+numInputs
  - last capture at cycle 3+numInputs
  - `NNvalid` rises at cycle 4+numInputs
- `maxValid` seen at cycle t → `resValid` at t+1, `NNvalid` low at t+1.
- Per-image overhead excluding network latency: numInputs+5 cycles.
- `start` coincident with `done` is ignored.
- Timeout fires after exactly `timeoutCycles` WAIT cycles without `maxValid`.

## Test plan
- Single image: `numImg`=1, RAM image 0 is a ramp; network model returns `maxValid` 20 cycles after `NNvalid` with index 7 → `NNin` slot k equals the ramp value at k, exactly 784 reads issued, `resValid` with `resImg`=0, `resIndex`=7, `done` one cycle after REPORT.
- Batch: `numImg`=8 with distinct images → 8 `resValid` pulses with `resImg` 0..7 in order, 2-cycle `nnReset` before each image, addresses contiguous 0..6271.
- Timeout: network model never responds, `timeoutCycles`=16 → `resIndex`=4'hF and `timeout`=1 after 16 WAIT cycles; the next image still runs; `timeout` clears on the next `start`.
- Edge counts: `numImg`=0 → `done` at cycle 1, no `memRd`. `numImg`=12 → 8 images run.
- `start` while busy, and `maxValid` pulsed during LOAD → no effect on state or results.
- Reset low for 1 cycle mid-LOAD → next cycle all outputs 0 and state IDLE; a new `start` runs normally.

Source files
------------

// File: rtl/nn_inference_sequencer.sv
// nn_inference_sequencer: batch run loop that loads images from RAM into a NeuralNetwork and reports each classification.
// Ports: clk/reset (sync, active-low); start/numImg request a batch; busy/done status;
// memAddr/memRd/memData image RAM (1-cycle read latency); nnReset/NNin/NNvalid drive the network;
// maxValid/maxIndex/maxValue network result; resValid/resImg/resIndex/resValue per-image report; timeout sticky flag.
module nn_inference_sequencer #(
  parameter int dataWidth = 16,
  parameter int numInputs = 784,
  parameter int numImages = 8,
  parameter int timeoutCycles = 4096,
  localparam int AW = $clog2(numImages * numInputs)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [3:0]                     numImg,
  output logic                           busy,
  output logic                           done,
  output logic [AW-1:0]                  memAddr,
  output logic                           memRd,
  input  logic [dataWidth-1:0]           memData,
  output logic                           nnReset,
  output logic [numInputs*dataWidth-1:0] NNin,
  output logic                           NNvalid,
  input  logic                           maxValid,
  input  logic [3:0]                     maxIndex,
  input  logic [dataWidth-1:0]           maxValue,
  output logic                           resValid,
  output logic [3:0]                     resImg,
  output logic [3:0]                     resIndex,
  output logic [dataWidth-1:0]           resValue,
  output logic                           timeout
);
  localparam int CW = $clog2((timeoutCycles > numInputs ? timeoutCycles : numInputs) + 1);
  localparam int PW = $clog2(numInputs);
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, FIRE, WAIT, REPORT, DONE} state_t;
  state_t state;
  logic [3:0] total, img, clamp;
  logic [CW-1:0] cnt;
  logic [PW-1:0] cap;
  logic rd_q;
  assign clamp = (numImg > 4'(numImages)) ? 4'(numImages) : numImg;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      {busy, done, memAddr, memRd, nnReset, NNin, NNvalid} <= '0;
      {resValid, resImg, resIndex, resValue, timeout} <= '0;
      {total, img, cnt, cap, rd_q} <= '0;
    end else begin
      // read data arrives one cycle after each strobe; capture it into the next pixel slot
      rd_q <= memRd;
      if (rd_q) begin
        NNin[cap*dataWidth +: dataWidth] <= memData;
        cap <= cap + 1'b1;
      end
      case (state)
        IDLE: if (start) begin
          total <= clamp;
          img <= '0;
          timeout <= 1'b0;
          cnt <= '0;
          if (clamp == 4'd0) begin
            state <= DONE;
            done <= 1'b1;
          end else begin
            state <= CLEAR;
            busy <= 1'b1;
            nnReset <= 1'b1;
          end
        end
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(1)) begin
            state <= LOAD;
            nnReset <= 1'b0;
            memRd <= 1'b1;
            memAddr <= AW'(img * numInputs);
            cnt <= '0;
            cap <= '0;
          end
        end
        // memRd low inside LOAD marks the extra cycle where the last word is captured
        LOAD: if (!memRd) begin
          state <= FIRE;
          NNvalid <= 1'b1;
        end else if (cnt == CW'(numInputs - 1)) begin
          memRd <= 1'b0;
        end else begin
          memAddr <= memAddr + 1'b1;
          cnt <= cnt + 1'b1;
        end
        FIRE: begin
          state <= WAIT;
          cnt <= '0;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (maxValid || cnt == CW'(timeoutCycles - 1)) begin
            state <= REPORT;
            NNvalid <= 1'b0;
            resValid <= 1'b1;
            resImg <= img;
            resIndex <= maxValid ? maxIndex : 4'hF;
            resValue <= maxValid ? maxValue : '0;
            timeout <= timeout | ~maxValid;
          end
        end
        REPORT: begin
          resValid <= 1'b0;
          if (img + 4'd1 < total) begin
            state <= CLEAR;
            img <= img + 4'd1;
            nnReset <= 1'b1;
            cnt <= '0;
          end else begin
            state <= DONE;
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
          done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
